// File: rtl/jfifo_sched_if.sv
// Bundles the producer, FIFO and consumer signals of the jFIFO scheduler.
// The master modport is the scheduler's view. The slave modport is the surrounding logic's view.
interface jfifo_sched_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             gnt0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             gnt1;
   logic             fifo_wn;
   logic [WIDTH-1:0] fifo_din;
   logic             fifo_full;
   logic             fifo_rn;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_empty;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CNT_W-1:0] gcnt0;
   logic [CNT_W-1:0] gcnt1;

   modport master (
      input  req0, data0, req1, data1, fifo_full, fifo_dout, fifo_empty, out_ready,
      output gnt0, gnt1, fifo_wn, fifo_din, fifo_rn, out_valid, out_data, gcnt0, gcnt1
   );

   modport slave (
      output req0, data0, req1, data1, fifo_full, fifo_dout, fifo_empty, out_ready,
      input  gnt0, gnt1, fifo_wn, fifo_din, fifo_rn, out_valid, out_data, gcnt0, gcnt1
   );
endinterface

// File: rtl/jfifo_sched.sv
// Shares one jFIFO-style queue between two producers and one consumer.
// Write side: a round-robin arbiter drives the single FIFO write port.
// Read side: a two-state FSM pops the FIFO and presents each word as a valid/ready stream.
module jfifo_sched #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   jfifo_sched_if.master     bus
);

   typedef enum logic {R_IDLE, R_VALID} rd_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   rd_state_t        rd_state;
   rd_state_t        rd_state_nx;
   logic             last_gnt;
   logic             gnt0;
   logic             gnt1;
   logic             rn;
   logic [WIDTH-1:0] din;
   logic [CNT_W-1:0] gcnt0_q;
   logic [CNT_W-1:0] gcnt1_q;

   // Grant selection: a full FIFO blocks every grant. When both producers request, the one not served last is granted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset && !bus.fifo_full) begin
         if (bus.req0 && bus.req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
         end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
         end
      end
   end

   // Write data mux: producer 1 data only while producer 1 is granted.
   always_comb begin
      din = bus.data0;
      if (gnt1) begin
         din = bus.data1;
      end
   end

   // Round-robin pointer: remembers the most recently granted producer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_gnt <= 1'b1;
      end else if (gnt0) begin
         last_gnt <= 1'b0;
      end else if (gnt1) begin
         last_gnt <= 1'b1;
      end
   end

   // Per-producer grant counters: each one stops at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
      end else begin
         if (gnt0 && (gcnt0_q != CNT_MAX)) begin
            gcnt0_q <= gcnt0_q + 1'b1;
         end
         if (gnt1 && (gcnt1_q != CNT_MAX)) begin
            gcnt1_q <= gcnt1_q + 1'b1;
         end
      end
   end

   // Read FSM state register. Reset discards any word waiting for the consumer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_state <= R_IDLE;
      end else begin
         rd_state <= rd_state_nx;
      end
   end

   // Read FSM next state and read enable: the FIFO is popped whenever the output slot is empty or being consumed.
   always_comb begin
      rd_state_nx = rd_state;
      rn          = 1'b0;
      case (rd_state)
         R_IDLE: begin
            rn = !bus.fifo_empty;
            if (rn) begin
               rd_state_nx = R_VALID;
            end
         end
         R_VALID: begin
            if (bus.out_ready) begin
               rn          = !bus.fifo_empty;
               rd_state_nx = rn ? R_VALID : R_IDLE;
            end
         end
         default: begin
            rd_state_nx = R_IDLE;
         end
      endcase
      if (!reset) begin
         rn = 1'b0;
      end
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.fifo_wn   = gnt0 | gnt1;
   assign bus.fifo_din  = din;
   assign bus.fifo_rn   = rn;
   assign bus.out_valid = (rd_state == R_VALID);
   assign bus.out_data  = bus.fifo_dout;
   assign bus.gcnt0     = gcnt0_q;
   assign bus.gcnt1     = gcnt1_q;

   a_gnt_onehot : assert property (@(posedge clock) disable iff (!reset) !(gnt0 && gnt1));
   a_no_wr_full : assert property (@(posedge clock) disable iff (!reset) bus.fifo_full |-> !bus.fifo_wn);

endmodule

// File: tb/tb_jfifo_sched.sv
// Bench for jfifo_sched. A queue-based FIFO sits around the DUT.
// A reference model predicts grants, counters and the order of consumer words.
module tb_jfifo_sched;

   localparam int WIDTH  = 8;
   localparam int CNT_W  = 4;
   localparam int FDEPTH = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clock;
   logic reset;

   jfifo_sched_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   jfifo_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks;
   int n_errors;

   // FIFO around the DUT
   logic [WIDTH-1:0] fq[$];
   logic             force_full;

   // reference model
   int               m_last;
   int               m_cnt0;
   int               m_cnt1;
   logic             m_valid;
   logic [WIDTH-1:0] m_word;
   logic [WIDTH-1:0] m_sent[$];

   // per-cycle expectations and observations
   logic             exp_gnt0, exp_gnt1, exp_wn, exp_rn, exp_valid;
   logic [WIDTH-1:0] exp_din, exp_data;
   int               exp_cnt0, exp_cnt1;
   logic             obs_gnt0, obs_gnt1, obs_wn, obs_rn, obs_valid;
   logic [WIDTH-1:0] obs_din, obs_data;
   logic [CNT_W-1:0] obs_cnt0, obs_cnt1;

   function automatic void env_flags();
      bus.fifo_full  = force_full || (fq.size() >= FDEPTH);
      bus.fifo_empty = (fq.size() == 0);
   endfunction

   function automatic void model_reset();
      m_last  = 1;
      m_cnt0  = 0;
      m_cnt1  = 0;
      m_valid = 1'b0;
   endfunction

   // Called at a negedge with inputs already set. Records predictions and observations, then advances one clock.
   task automatic drive_cycle();
      int pre_size;
      #1;
      exp_gnt0 = 1'b0;
      exp_gnt1 = 1'b0;
      if (!bus.fifo_full) begin
         if (bus.req0 && bus.req1) begin
            if (m_last == 0) exp_gnt1 = 1'b1;
            else             exp_gnt0 = 1'b1;
         end else if (bus.req0) begin
            exp_gnt0 = 1'b1;
         end else if (bus.req1) begin
            exp_gnt1 = 1'b1;
         end
      end
      exp_wn    = exp_gnt0 | exp_gnt1;
      exp_din   = exp_gnt1 ? bus.data1 : bus.data0;
      exp_rn    = !bus.fifo_empty && (!m_valid || bus.out_ready);
      exp_valid = m_valid;
      exp_data  = m_word;
      exp_cnt0  = m_cnt0;
      exp_cnt1  = m_cnt1;
      obs_gnt0  = bus.gnt0;
      obs_gnt1  = bus.gnt1;
      obs_wn    = bus.fifo_wn;
      obs_din   = bus.fifo_din;
      obs_rn    = bus.fifo_rn;
      obs_valid = bus.out_valid;
      obs_data  = bus.out_data;
      obs_cnt0  = bus.gcnt0;
      obs_cnt1  = bus.gcnt1;
      @(posedge clock);
      #1;
      // model: consumer slot first (reads see pre-edge contents), then accepted writes
      if (exp_rn) begin
         m_valid = 1'b1;
         if (m_sent.size() > 0) m_word = m_sent.pop_front();
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
      if (exp_gnt0) begin
         m_last = 0;
         if (m_cnt0 < CMAX) m_cnt0++;
         m_sent.push_back(bus.data0);
      end
      if (exp_gnt1) begin
         m_last = 1;
         if (m_cnt1 < CMAX) m_cnt1++;
         m_sent.push_back(bus.data1);
      end
      // FIFO reacts to what the DUT actually drove
      pre_size = fq.size();
      if (obs_rn && pre_size > 0) bus.fifo_dout = fq.pop_front();
      if (obs_wn && pre_size < FDEPTH) fq.push_back(obs_din);
      env_flags();
      @(negedge clock);
   endtask

   task automatic drain();
      bus.req0      = 1'b0;
      bus.req1      = 1'b0;
      bus.out_ready = 1'b1;
      force_full    = 1'b0;
      env_flags();
      for (int i = 0; i < 20 && (m_valid || fq.size() > 0 || bus.out_valid); i++) drive_cycle();
      n_checks++;
      if (bus.out_valid !== 1'b0 || fq.size() != 0) begin
         n_errors++;
         $display("FAIL drain: out_valid=%0b fifo_size=%0d, required 0 and 0", bus.out_valid, fq.size());
      end
   endtask

   task automatic preload(input logic [WIDTH-1:0] w);
      fq.push_back(w);
      m_sent.push_back(w);
      env_flags();
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.req0      = 1'b0;
      bus.req1      = 1'b0;
      bus.data0     = '0;
      bus.data1     = '0;
      bus.out_ready = 1'b0;
      bus.fifo_dout = '0;
      force_full    = 1'b0;
      fq.delete();
      m_sent.delete();
      m_word        = '0;
      env_flags();
      model_reset();
      #1;
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.fifo_wn, bus.fifo_rn, bus.out_valid} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: gnt0,gnt1,wn,rn,valid=%b, required 00000",
                  {bus.gnt0, bus.gnt1, bus.fifo_wn, bus.fifo_rn, bus.out_valid});
      end
      n_checks++;
      if (bus.gcnt0 !== '0 || bus.gcnt1 !== '0) begin
         n_errors++;
         $display("FAIL reset_cnt: gcnt0=%0d gcnt1=%0d, required 0 0", bus.gcnt0, bus.gcnt1);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      drive_cycle();
      n_checks++;
      if ({obs_gnt0, obs_gnt1, obs_wn, obs_rn, obs_valid} !== 5'b0) begin
         n_errors++;
         $display("FAIL idle_after_reset: gnt0,gnt1,wn,rn,valid=%b, required 00000",
                  {obs_gnt0, obs_gnt1, obs_wn, obs_rn, obs_valid});
      end
   endtask

   task automatic test_round_robin();
      bus.req0      = 1'b1;
      bus.req1      = 1'b1;
      bus.data0     = 8'd100;
      bus.data1     = 8'd150;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_cycle();
         n_checks++;
         if (obs_gnt0 !== (i % 2 == 0) || obs_gnt1 !== (i % 2 == 1) || obs_wn !== 1'b1) begin
            n_errors++;
            $display("FAIL rr_grant[%0d]: gnt0=%0b gnt1=%0b wn=%0b, required %0b %0b 1",
                     i, obs_gnt0, obs_gnt1, obs_wn, (i % 2 == 0), (i % 2 == 1));
         end
         n_checks++;
         if (obs_din !== ((i % 2 == 0) ? 8'd100 : 8'd150)) begin
            n_errors++;
            $display("FAIL rr_din[%0d]: got %0d, required %0d", i, obs_din, (i % 2 == 0) ? 100 : 150);
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      drive_cycle();
      n_checks++;
      if (obs_cnt0 !== 4'd2 || obs_cnt1 !== 4'd2) begin
         n_errors++;
         $display("FAIL rr_counts: gcnt0=%0d gcnt1=%0d, required 2 2", obs_cnt0, obs_cnt1);
      end
      drain();
   endtask

   task automatic test_full_block();
      force_full = 1'b1;
      bus.req0   = 1'b1;
      bus.data0  = 8'd33;
      env_flags();
      for (int i = 0; i < 2; i++) begin
         drive_cycle();
         n_checks++;
         if (obs_gnt0 !== 1'b0 || obs_wn !== 1'b0 || obs_cnt0 !== 4'd2) begin
            n_errors++;
            $display("FAIL full_block[%0d]: gnt0=%0b wn=%0b gcnt0=%0d, required 0 0 2",
                     i, obs_gnt0, obs_wn, obs_cnt0);
         end
      end
      force_full = 1'b0;
      env_flags();
      drive_cycle();
      n_checks++;
      if (obs_gnt0 !== 1'b1 || obs_wn !== 1'b1 || obs_din !== 8'd33) begin
         n_errors++;
         $display("FAIL full_release: gnt0=%0b wn=%0b din=%0d, required 1 1 33", obs_gnt0, obs_wn, obs_din);
      end
      bus.req0 = 1'b0;
      drive_cycle();
      n_checks++;
      if (obs_cnt0 !== 4'd3) begin
         n_errors++;
         $display("FAIL full_count: gcnt0=%0d, required 3", obs_cnt0);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic             ev[5];
      logic             er[5];
      logic [WIDTH-1:0] ed[5];
      ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ed = '{8'd0, 8'd100, 8'd150, 8'd200, 8'd0};
      preload(8'd100);
      preload(8'd150);
      preload(8'd200);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_cycle();
         n_checks++;
         if (obs_valid !== ev[i] || obs_rn !== er[i] || (ev[i] && obs_data !== ed[i])) begin
            n_errors++;
            $display("FAIL b2b[%0d]: valid=%0b rn=%0b data=%0d, required %0b %0b %0d",
                     i, obs_valid, obs_rn, obs_data, ev[i], er[i], ed[i]);
         end
      end
   endtask

   task automatic test_stall();
      preload(8'd40);
      preload(8'd77);
      bus.out_ready = 1'b0;
      drive_cycle();
      n_checks++;
      if (obs_rn !== 1'b1 || obs_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_first_pop: rn=%0b valid=%0b, required 1 0", obs_rn, obs_valid);
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle();
         n_checks++;
         if (obs_valid !== 1'b1 || obs_data !== 8'd40 || obs_rn !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: valid=%0b data=%0d rn=%0b, required 1 40 0",
                     i, obs_valid, obs_data, obs_rn);
         end
      end
      bus.out_ready = 1'b1;
      drive_cycle();
      n_checks++;
      if (obs_valid !== 1'b1 || obs_data !== 8'd40 || obs_rn !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_release: valid=%0b data=%0d rn=%0b, required 1 40 1", obs_valid, obs_data, obs_rn);
      end
      drive_cycle();
      n_checks++;
      if (obs_valid !== 1'b1 || obs_data !== 8'd77) begin
         n_errors++;
         $display("FAIL stall_next: valid=%0b data=%0d, required 1 77", obs_valid, obs_data);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      preload(8'd55);
      preload(8'd66);
      bus.out_ready = 1'b0;
      drive_cycle();
      drive_cycle();
      n_checks++;
      if (obs_valid !== 1'b1 || obs_data !== 8'd55) begin
         n_errors++;
         $display("FAIL rst_setup: valid=%0b data=%0d, required 1 55", obs_valid, obs_data);
      end
      bus.req0  = 1'b1;
      bus.data0 = 8'd9;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.gcnt0 !== '0 || bus.gcnt1 !== '0) begin
         n_errors++;
         $display("FAIL rst_async: valid=%0b gcnt0=%0d gcnt1=%0d, required 0 0 0",
                  bus.out_valid, bus.gcnt0, bus.gcnt1);
      end
      n_checks++;
      if (bus.gnt0 !== 1'b0 || bus.fifo_wn !== 1'b0 || bus.fifo_rn !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_gating: gnt0=%0b wn=%0b rn=%0b, required 0 0 0", bus.gnt0, bus.fifo_wn, bus.fifo_rn);
      end
      model_reset();
      @(negedge clock);
      reset     = 1'b1;
      bus.req1  = 1'b1;
      bus.data1 = 8'd10;
      bus.out_ready = 1'b1;
      drive_cycle();
      n_checks++;
      if (obs_gnt0 !== 1'b1 || obs_gnt1 !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_rr_restart: gnt0=%0b gnt1=%0b, required 1 0", obs_gnt0, obs_gnt1);
      end
      drain();
   endtask

   task automatic test_saturation();
      bus.req0      = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.data0 = WIDTH'($urandom);
         drive_cycle();
      end
      bus.req0 = 1'b0;
      drive_cycle();
      n_checks++;
      if (obs_cnt0 !== 4'hF) begin
         n_errors++;
         $display("FAIL saturate: gcnt0=%0d, required 15", obs_cnt0);
      end
      drain();
   endtask

   task automatic test_random();
      logic             p_req[2];
      logic [WIDTH-1:0] p_dat[2];
      p_req = '{1'b0, 1'b0};
      p_dat = '{8'd0, 8'd0};
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!p_req[p]) begin
               if ($urandom_range(0, 99) < 55) begin
                  p_req[p] = 1'b1;
                  p_dat[p] = WIDTH'($urandom);
               end
            end else if ($urandom_range(0, 99) < 5) begin
               p_req[p] = 1'b0;
            end
         end
         bus.req0      = p_req[0];
         bus.data0     = p_dat[0];
         bus.req1      = p_req[1];
         bus.data1     = p_dat[1];
         bus.out_ready = ($urandom_range(0, 99) < 50);
         force_full    = ($urandom_range(0, 9) == 0);
         env_flags();
         drive_cycle();
         n_checks++;
         if (obs_gnt0 !== exp_gnt0 || obs_gnt1 !== exp_gnt1 || obs_wn !== exp_wn) begin
            n_errors++;
            $display("FAIL rnd_grant@%0d: gnt0=%0b gnt1=%0b wn=%0b, required %0b %0b %0b",
                     c, obs_gnt0, obs_gnt1, obs_wn, exp_gnt0, exp_gnt1, exp_wn);
         end
         if (exp_wn) begin
            n_checks++;
            if (obs_din !== exp_din) begin
               n_errors++;
               $display("FAIL rnd_din@%0d: got %0d, required %0d", c, obs_din, exp_din);
            end
         end
         n_checks++;
         if (obs_rn !== exp_rn || obs_valid !== exp_valid) begin
            n_errors++;
            $display("FAIL rnd_read@%0d: rn=%0b valid=%0b, required %0b %0b", c, obs_rn, obs_valid, exp_rn, exp_valid);
         end
         if (exp_valid) begin
            n_checks++;
            if (obs_data !== exp_data) begin
               n_errors++;
               $display("FAIL rnd_data@%0d: got %0d, required %0d", c, obs_data, exp_data);
            end
         end
         n_checks++;
         if (int'(obs_cnt0) != exp_cnt0 || int'(obs_cnt1) != exp_cnt1) begin
            n_errors++;
            $display("FAIL rnd_count@%0d: gcnt0=%0d gcnt1=%0d, required %0d %0d",
                     c, obs_cnt0, obs_cnt1, exp_cnt0, exp_cnt1);
         end
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? obs_gnt0 : obs_gnt1) p_req[p] = 1'b0;
         end
      end
      drain();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_round_robin();
      test_full_block();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
